// File: rtl/upuart_ocp_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : upuart_ocp_defs (package)
// Purpose  : Shared OCP command/response codes and the slave FSM state
//            encoding used by the UltiSoC peripheral OCP front-end.
// Contents : OCP_CMD_*  - MCmd encodings (values other than READ/WRITE idle)
//            OCP_RESP_* - SResp encodings
//            ST_*       - upuart_ocp_slave state encoding (ST_W bits)
// Revision : 1.0 - initial release
// ============================================================================
package upuart_ocp_defs;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
  localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
  localparam logic [2:0] OCP_CMD_READ  = 3'd2;

  localparam logic [1:0] OCP_RESP_NULL = 2'd0;
  localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
  localparam logic [1:0] OCP_RESP_FAIL = 2'd2;
  localparam logic [1:0] OCP_RESP_ERR  = 2'd3;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_ACCESS = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/upuart_ocp_decode.sv
`default_nettype none
// ============================================================================
// Module   : upuart_ocp_decode
// Purpose  : Combinational address decode for the OCP register front-end:
//            word index, one-hot select, misalignment, range and read-only
//            violation checks.
// Ports    : i_addr     - OCP byte address
//            i_is_write - command is a WRITE (enables read-only check)
//            o_sel      - one-hot register select (all zero if out of range)
//            o_err      - misaligned, out of range, or write to RO register
// Revision : 1.0 - initial release
// ============================================================================
module upuart_ocp_decode #(
  parameter int               ADDR_WIDTH = 32,
  parameter int               BEN_WIDTH  = 4,
  parameter int               NREGS      = 4,
  parameter logic [NREGS-1:0] RO_MASK    = 'b1000
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_is_write,
  output logic [NREGS-1:0]      o_sel,
  output logic                  o_err
);

  // A single-byte data path has no sub-word address bits to check.
  localparam int                    c_LSB      = (BEN_WIDTH > 1) ? $clog2(BEN_WIDTH) : 0;
  localparam logic [ADDR_WIDTH-1:0] c_LOW_MASK = ADDR_WIDTH'(BEN_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_NREGS    = ADDR_WIDTH'(NREGS);

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_misalign;
  logic                  w_in_range;
  logic                  w_ro_hit;

  assign w_idx      = i_addr >> c_LSB;
  assign w_misalign = |(i_addr & c_LOW_MASK);
  assign w_in_range = (w_idx < c_NREGS);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_sel
      assign o_sel[gi] = (w_idx == ADDR_WIDTH'(gi));
    end
  endgenerate

  // o_sel is zero when out of range, so the RO lookup needs no extra guard.
  assign w_ro_hit = i_is_write & (|(o_sel & RO_MASK));
  assign o_err    = w_misalign | ~w_in_range | w_ro_hit;

endmodule
`default_nettype wire

// File: rtl/upuart_ocp_slave.sv
`default_nettype none
// ============================================================================
// Module   : upuart_ocp_slave
// Purpose  : Registered OCP slave front-end for peripheral register files.
//            Accepts one command at a time, holds rd/wr to the register file
//            until i_ack (wait states allowed, optional timeout), and returns
//            a one-cycle DVA/ERR/FAIL response.
// Ports    : clk, nrst                       - clock, async active-low reset
//            i_MAddr/i_MCmd/i_MData/i_MByteEn - OCP request from master
//            o_SCmdAccept/o_SData/o_SResp    - OCP accept and response
//            o_rd/o_wr/o_sel/o_wdata/o_ben   - register-file request
//            i_rdata/i_ack                   - register-file completion
// Revision : 1.0 - initial release
// ============================================================================
module upuart_ocp_slave #(
  parameter int               ADDR_WIDTH = 32,
  parameter int               DATA_WIDTH = 32,
  parameter int               BEN_WIDTH  = DATA_WIDTH / 8,
  parameter int               NREGS      = 4,
  parameter logic [NREGS-1:0] RO_MASK    = 'b1000,
  parameter int               TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]            i_MCmd,
  input  logic [DATA_WIDTH-1:0] i_MData,
  input  logic [BEN_WIDTH-1:0]  i_MByteEn,
  output logic                  o_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_SData,
  output logic [1:0]            o_SResp,
  output logic                  o_rd,
  output logic                  o_wr,
  output logic [NREGS-1:0]      o_sel,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [BEN_WIDTH-1:0]  o_ben,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_ack
);

  import upuart_ocp_defs::*;

  localparam int              c_TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_TW-1:0] c_TMAX  = c_TW'(TIMEOUT);
  // Count value during the last permitted ACCESS cycle.
  localparam logic [c_TW-1:0] c_TLAST = (TIMEOUT > 0) ? c_TW'(TIMEOUT - 1) : '0;

  logic [ST_W-1:0]       r_state;
  logic [ST_W-1:0]       w_next;
  logic [c_TW-1:0]       r_tcnt;
  logic [1:0]            r_resp;
  logic [DATA_WIDTH-1:0] r_sdata;
  logic                  r_rd;
  logic                  r_wr;
  logic [NREGS-1:0]      r_sel;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BEN_WIDTH-1:0]  r_ben;

  logic             w_cmd_rd;
  logic             w_cmd_wr;
  logic             w_accept;
  logic [NREGS-1:0] w_sel;
  logic             w_err;
  logic             w_no_bytes;
  logic             w_expire;

  assign w_cmd_rd   = (i_MCmd == OCP_CMD_READ);
  assign w_cmd_wr   = (i_MCmd == OCP_CMD_WRITE);
  assign w_accept   = (r_state == ST_IDLE) && (w_cmd_rd || w_cmd_wr);
  assign w_no_bytes = w_cmd_wr && (i_MByteEn == '0);
  assign w_expire   = (TIMEOUT > 0) && (r_tcnt == c_TLAST);

  upuart_ocp_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BEN_WIDTH  (BEN_WIDTH),
    .NREGS      (NREGS),
    .RO_MASK    (RO_MASK)
  ) u_decode (
    .i_addr     (i_MAddr),
    .i_is_write (w_cmd_wr),
    .o_sel      (w_sel),
    .o_err      (w_err)
  );

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; errors and empty writes skip the register file.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (w_err || w_no_bytes) ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (i_ack || w_expire) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_SCmdAccept = (r_state == ST_IDLE);
  end

  // Wait-state counter: zero outside ACCESS, saturating inside.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tcnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_tcnt <= '0;
    end else if (r_tcnt != c_TMAX) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // Registered request and response datapath.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_resp  <= OCP_RESP_NULL;
      r_sdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_ben   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              r_resp  <= OCP_RESP_ERR;
              r_sdata <= w_cmd_rd ? '1 : '0;
            end else if (w_no_bytes) begin
              r_resp  <= OCP_RESP_DVA;
            end else begin
              r_sel   <= w_sel;
              r_wdata <= i_MData;
              r_ben   <= i_MByteEn;
              r_rd    <= w_cmd_rd;
              r_wr    <= w_cmd_wr;
            end
          end
        end
        ST_ACCESS: begin
          // An ack on the expiry cycle still completes the access.
          if (i_ack) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_sel   <= '0;
            r_resp  <= OCP_RESP_DVA;
            r_sdata <= r_rd ? i_rdata : '0;
          end else if (w_expire) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_sel   <= '0;
            r_resp  <= OCP_RESP_FAIL;
            r_sdata <= '1;
          end
        end
        default: begin
          r_resp  <= OCP_RESP_NULL;
          r_sdata <= '0;
        end
      endcase
    end
  end

  assign o_SResp = r_resp;
  assign o_SData = r_sdata;
  assign o_rd    = r_rd;
  assign o_wr    = r_wr;
  assign o_sel   = r_sel;
  assign o_wdata = r_wdata;
  assign o_ben   = r_ben;

endmodule
`default_nettype wire
